// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_* channel responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } mem_chan_state_t;

  localparam int unsigned LATENCY_CNT_BITS = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Read/write channel bundle between a memory controller (master) and the responder (slave).
interface mem_responder_if #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4
);

  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;

  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );

endinterface

// File: rtl/mem_chan_fsm.sv
// Per-channel request handshake: IDLE -> WAIT (latency countdown) -> RESPOND -> IDLE.
module mem_chan_fsm
  import mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  output logic capture,
  output logic commit,
  output logic ready
);

  mem_chan_state_t             state_q, state_d;
  logic [LATENCY_CNT_BITS-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = WAIT;
          cnt_d   = LATENCY_CNT_BITS'(LATENCY - 1);
          capture = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESPOND;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - LATENCY_CNT_BITS'(1);
        end
      end
      RESPOND: begin
        // Valid must be seen low before a new request can start.
        if (!valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == RESPOND);

endmodule

// File: rtl/mem_responder.sv
// Multi-channel fixed-latency memory responder with a preload port.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned LATENCY      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  input  logic                 load_enable,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data
);

  localparam int unsigned Rows = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem_q [Rows];

  logic [NUM_CHANNELS-1:0] rd_capture, rd_commit, rd_ready;
  logic [NUM_CHANNELS-1:0] wr_capture, wr_commit, wr_ready;

  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_addr_q, wr_addr_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_data_q, rd_data_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    mem_chan_fsm #(
      .LATENCY(LATENCY)
    ) u_rd_fsm (
      .clk    (clk),
      .reset  (reset),
      .valid  (bus.mem_read_valid[c]),
      .capture(rd_capture[c]),
      .commit (rd_commit[c]),
      .ready  (rd_ready[c])
    );

    mem_chan_fsm #(
      .LATENCY(LATENCY)
    ) u_wr_fsm (
      .clk    (clk),
      .reset  (reset),
      .valid  (bus.mem_write_valid[c]),
      .capture(wr_capture[c]),
      .commit (wr_commit[c]),
      .ready  (wr_ready[c])
    );
  end

  // Request fields are frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      if (rd_capture[c]) begin
        rd_addr_q[c] <= bus.mem_read_address[c];
      end
      if (wr_capture[c]) begin
        wr_addr_q[c] <= bus.mem_write_address[c];
        wr_data_q[c] <= bus.mem_write_data[c];
      end
    end
  end

  // Reads sample the array before this edge's writes land (read-before-write).
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        if (rd_commit[c]) begin
          rd_data_q[c] <= mem_q[rd_addr_q[c]];
        end
      end
    end
  end

  // Later assignments win: channels high-to-low so channel 0 beats the rest, load beats all.
  always_ff @(posedge clk) begin
    for (int c = int'(NUM_CHANNELS) - 1; c >= 0; c--) begin
      if (wr_commit[c] && !reset) begin
        mem_q[wr_addr_q[c]] <= wr_data_q[c];
      end
    end
    if (load_enable) begin
      mem_q[load_address] <= load_data;
    end
  end

  assign bus.mem_read_ready  = rd_ready;
  assign bus.mem_read_data   = rd_data_q;
  assign bus.mem_write_ready = wr_ready;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: transaction-level array model against directed and random rounds.
module tb_mem_responder;

  localparam int unsigned AddrBits = 8;
  localparam int unsigned DataBits = 8;
  localparam int unsigned NumCh    = 4;
  localparam int unsigned Latency  = 2;

  logic clk = 1'b0;
  logic reset;
  logic load_enable;
  logic [AddrBits-1:0] load_address;
  logic [DataBits-1:0] load_data;

  mem_responder_if #(
    .ADDR_BITS   (AddrBits),
    .DATA_BITS   (DataBits),
    .NUM_CHANNELS(NumCh)
  ) bus ();

  mem_responder #(
    .ADDR_BITS   (AddrBits),
    .DATA_BITS   (DataBits),
    .NUM_CHANNELS(NumCh),
    .LATENCY     (Latency)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .load_enable (load_enable),
    .load_address(load_address),
    .load_data   (load_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]      ref_mem [256];
  logic [3:0][7:0] last_rd;
  logic [3:0][7:0] ra, wa, wd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One batch of requests all raised before the same edge; the model commits them together.
  task automatic run_round(input logic [3:0] rmask, input logic [3:0] wmask,
                           input logic [3:0][7:0] raddr, input logic [3:0][7:0] waddr,
                           input logic [3:0][7:0] wdata, input bit do_load,
                           input logic [7:0] laddr, input logic [7:0] ldata,
                           input bit early_drop);
    logic [3:0][7:0] exp_rd;
    exp_rd = last_rd;
    for (int c = 0; c < 4; c++) if (rmask[c]) exp_rd[c] = ref_mem[raddr[c]];
    for (int c = 3; c >= 0; c--) if (wmask[c]) ref_mem[waddr[c]] = wdata[c];
    if (do_load) ref_mem[laddr] = ldata;

    bus.mem_read_valid    = rmask;
    bus.mem_read_address  = raddr;
    bus.mem_write_valid   = wmask;
    bus.mem_write_address = waddr;
    bus.mem_write_data    = wdata;
    tick();
    if (early_drop) begin
      bus.mem_read_valid  = '0;
      bus.mem_write_valid = '0;
    end
    bus.mem_read_address  = 32'($urandom);
    bus.mem_write_address = 32'($urandom);
    bus.mem_write_data    = 32'($urandom);

    for (int k = 0; k < int'(Latency); k++) begin
      check_eq("rd_ready_wait", 32'(bus.mem_read_ready), 32'(0));
      check_eq("wr_ready_wait", 32'(bus.mem_write_ready), 32'(0));
      if (k == int'(Latency) - 1 && do_load) begin
        load_enable  = 1'b1;
        load_address = laddr;
        load_data    = ldata;
      end
      tick();
    end
    load_enable = 1'b0;

    check_eq("rd_ready_rise", 32'(bus.mem_read_ready), 32'(rmask));
    check_eq("wr_ready_rise", 32'(bus.mem_write_ready), 32'(wmask));
    check_eq("rd_data", 32'(bus.mem_read_data), 32'(exp_rd));
    last_rd = exp_rd;

    if (!early_drop) begin
      tick();
      check_eq("rd_ready_held", 32'(bus.mem_read_ready), 32'(rmask));
      check_eq("wr_ready_held", 32'(bus.mem_write_ready), 32'(wmask));
      bus.mem_read_valid  = '0;
      bus.mem_write_valid = '0;
    end
    tick();
    check_eq("rd_ready_fall", 32'(bus.mem_read_ready), 32'(0));
    check_eq("wr_ready_fall", 32'(bus.mem_write_ready), 32'(0));
    check_eq("rd_data_hold", 32'(bus.mem_read_data), 32'(last_rd));
  endtask

  initial begin
    reset                 = 1'b1;
    load_enable           = 1'b0;
    load_address          = '0;
    load_data             = '0;
    bus.mem_read_valid    = '0;
    bus.mem_read_address  = '0;
    bus.mem_write_valid   = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
    last_rd               = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset_rd_ready", 32'(bus.mem_read_ready), 32'(0));
    check_eq("reset_wr_ready", 32'(bus.mem_write_ready), 32'(0));
    check_eq("reset_rd_data", 32'(bus.mem_read_data), 32'(0));

    // Preload every row so the model and the array start identical.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (i == 'h10) v = 8'hA5;
      if (i == 'h30) v = 8'h00;
      if (i == 'h40) v = 8'h01;
      ref_mem[i]   = v;
      load_enable  = 1'b1;
      load_address = 8'(i);
      load_data    = v;
      tick();
    end
    load_enable = 1'b0;

    // Basic read of a preloaded row.
    ra = '0; wa = '0; wd = '0;
    ra[0] = 8'h10;
    run_round(4'b0001, 4'b0000, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);

    // Write through one channel, read back through another.
    ra = '0; wa = '0; wd = '0;
    wa[1] = 8'h20; wd[1] = 8'h3C;
    run_round(4'b0000, 4'b0010, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);
    ra[2] = 8'h20;
    run_round(4'b0100, 4'b0000, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);

    // Same-row write conflict, then with a load on the commit edge.
    ra = '0; wa = '0; wd = '0;
    wa[0] = 8'h05; wd[0] = 8'h11; wa[3] = 8'h05; wd[3] = 8'h22;
    run_round(4'b0000, 4'b1001, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);
    ra[0] = 8'h05;
    run_round(4'b0001, 4'b0000, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);
    run_round(4'b0000, 4'b1001, ra, wa, wd, 1'b1, 8'h05, 8'h33, 1'b0);
    run_round(4'b0001, 4'b0000, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);

    // Read and write of one row committing together.
    ra = '0; wa = '0; wd = '0;
    ra[0] = 8'h40; wa[1] = 8'h40; wd[1] = 8'h02;
    run_round(4'b0001, 4'b0010, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);
    run_round(4'b0001, 4'b0000, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);

    // All read channels at once to distinct rows.
    ra = '0; wa = '0; wd = '0;
    ra[0] = 8'h10; ra[1] = 8'h20; ra[2] = 8'h05; ra[3] = 8'h40;
    run_round(4'b1111, 4'b0000, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);

    // Valid dropped during WAIT still completes with a one-cycle ready pulse.
    ra = '0; wa = '0; wd = '0;
    ra[1] = 8'h77; wa[2] = 8'h78; wd[2] = 8'h5A;
    run_round(4'b0010, 4'b0100, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b1);

    // Reset on the edge that would commit a write: nothing lands.
    wa = '0; wd = '0;
    wa[0] = 8'h30; wd[0] = 8'h77;
    bus.mem_write_valid   = 4'b0001;
    bus.mem_write_address = wa;
    bus.mem_write_data    = wd;
    for (int k = 0; k < int'(Latency); k++) begin
      tick();
      check_eq("rst_wait_ready", 32'(bus.mem_write_ready), 32'(0));
    end
    reset = 1'b1;
    tick();
    reset               = 1'b0;
    bus.mem_write_valid = '0;
    last_rd             = '0;
    check_eq("rst_rd_ready", 32'(bus.mem_read_ready), 32'(0));
    check_eq("rst_wr_ready", 32'(bus.mem_write_ready), 32'(0));
    check_eq("rst_rd_data", 32'(bus.mem_read_data), 32'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("rst_idle_ready", 32'({bus.mem_read_ready, bus.mem_write_ready}), 32'(0));
    end
    ra = '0; wa = '0; wd = '0;
    ra[3] = 8'h30;
    run_round(4'b1000, 4'b0000, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random batches over a narrow row range to provoke conflicts.
    for (int r = 0; r < 60; r++) begin
      logic [3:0] rm, wm;
      logic [7:0] la, ld;
      bit         dl, ed;
      rm = 4'($urandom);
      wm = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        ra[c] = 8'($urandom_range(0, 7));
        wa[c] = 8'($urandom_range(0, 7));
        wd[c] = 8'($urandom);
      end
      dl = ($urandom_range(0, 3) == 0);
      ed = ($urandom_range(0, 4) == 0);
      la = 8'($urandom_range(0, 7));
      ld = 8'($urandom);
      run_round(rm, wm, ra, wa, wd, dl, la, ld, ed);
    end

    // Final sweep of the conflict rows through channel 0 reads.
    for (int i = 0; i < 8; i++) begin
      ra = '0;
      ra[0] = 8'(i);
      run_round(4'b0001, 4'b0000, ra, wa, wd, 1'b0, 8'h00, 8'h00, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
